// File: rtl/fma_operand_sequencer.sv
// Operand sequencer for a BF16 FMA: a debounced pushbutton loads A, B and C from the
// switches, launches the FMA, then shows its result (or a timeout code) on the display.
module fma_operand_sequencer #(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int FMA_TIMEOUT     = 255
) (
   input  logic        clk_100MHz,
   input  logic        reset,
   input  logic [15:0] sw,
   input  logic        btn_load,
   input  logic        fma_done,
   input  logic [15:0] fma_result,
   output logic [15:0] op_a,
   output logic [15:0] op_b,
   output logic [15:0] op_c,
   output logic        fma_start,
   output logic [15:0] data_out,
   output logic        dm_write,
   output logic [2:0]  stage,
   output logic        error
);
   localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int TO_W = $clog2(FMA_TIMEOUT + 1);
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(FMA_TIMEOUT - 1);
   localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);
   localparam logic [15:0]     TIMEOUT_CODE = 16'hEEEE;

   typedef enum logic [2:0] {
      LOAD_A = 3'd0,
      LOAD_B = 3'd1,
      LOAD_C = 3'd2,
      START  = 3'd3,
      WAIT   = 3'd4,
      SHOW   = 3'd5
   } state_t;

   logic            sync1_r, sync2_r, deb_r, deb_d_r;
   logic [DB_W-1:0] db_cnt_r;
   logic            press_s;

   state_t          state_r, state_s;
   logic [15:0]     op_a_r, op_a_s, op_b_r, op_b_s, op_c_r, op_c_s;
   logic [15:0]     data_r, data_s;
   logic            dmw_r, dmw_s, start_r, start_s, err_r, err_s;
   logic [TO_W-1:0] wait_cnt_r, wait_cnt_s;

   // Synchronize the raw button and accept a new level only after it has been stable long enough
   always_ff @(posedge clk_100MHz) begin
      if (reset) begin
         sync1_r  <= 1'b0;
         sync2_r  <= 1'b0;
         deb_r    <= 1'b0;
         deb_d_r  <= 1'b0;
         db_cnt_r <= '0;
      end else begin
         sync1_r <= btn_load;
         sync2_r <= sync1_r;
         deb_d_r <= deb_r;
         if (sync2_r != deb_r) begin
            if (db_cnt_r == DB_LAST) begin
               deb_r    <= sync2_r;
               db_cnt_r <= '0;
            end else begin
               db_cnt_r <= db_cnt_r + DB_ONE;
            end
         end else begin
            db_cnt_r <= '0;
         end
      end
   end

   // A press is the single cycle in which the debounced level has just risen
   assign press_s = deb_r & ~deb_d_r;

   // Sequencer state and registered outputs
   always_ff @(posedge clk_100MHz) begin
      if (reset) begin
         state_r    <= LOAD_A;
         op_a_r     <= 16'h0000;
         op_b_r     <= 16'h0000;
         op_c_r     <= 16'h0000;
         data_r     <= 16'h0000;
         dmw_r      <= 1'b0;
         start_r    <= 1'b0;
         err_r      <= 1'b0;
         wait_cnt_r <= '0;
      end else begin
         state_r    <= state_s;
         op_a_r     <= op_a_s;
         op_b_r     <= op_b_s;
         op_c_r     <= op_c_s;
         data_r     <= data_s;
         dmw_r      <= dmw_s;
         start_r    <= start_s;
         err_r      <= err_s;
         wait_cnt_r <= wait_cnt_s;
      end
   end

   // Next-state and next-output decode; strobes default low so they last one cycle
   always_comb begin
      state_s    = state_r;
      op_a_s     = op_a_r;
      op_b_s     = op_b_r;
      op_c_s     = op_c_r;
      data_s     = data_r;
      dmw_s      = 1'b0;
      start_s    = 1'b0;
      err_s      = err_r;
      wait_cnt_s = wait_cnt_r;
      case (state_r)
         LOAD_A: begin
            if (press_s) begin
               op_a_s  = sw;
               data_s  = sw;
               dmw_s   = 1'b1;
               state_s = LOAD_B;
            end else begin
               state_s = LOAD_A;
            end
         end
         LOAD_B: begin
            if (press_s) begin
               op_b_s  = sw;
               data_s  = sw;
               dmw_s   = 1'b1;
               state_s = LOAD_C;
            end else begin
               state_s = LOAD_B;
            end
         end
         LOAD_C: begin
            if (press_s) begin
               op_c_s  = sw;
               data_s  = sw;
               dmw_s   = 1'b1;
               state_s = START;
            end else begin
               state_s = LOAD_C;
            end
         end
         START: begin
            start_s    = 1'b1;
            wait_cnt_s = '0;
            state_s    = WAIT;
         end
         WAIT: begin
            // A result arriving on the last allowed cycle still beats the timeout
            if (fma_done) begin
               data_s  = fma_result;
               dmw_s   = 1'b1;
               state_s = SHOW;
            end else if (wait_cnt_r == TO_LAST) begin
               err_s   = 1'b1;
               data_s  = TIMEOUT_CODE;
               dmw_s   = 1'b1;
               state_s = SHOW;
            end else begin
               wait_cnt_s = wait_cnt_r + TO_ONE;
               state_s    = WAIT;
            end
         end
         SHOW: begin
            if (press_s) begin
               err_s   = 1'b0;
               state_s = LOAD_A;
            end else begin
               state_s = SHOW;
            end
         end
         default: begin
            state_s = LOAD_A;
         end
      endcase
   end

   assign op_a      = op_a_r;
   assign op_b      = op_b_r;
   assign op_c      = op_c_r;
   assign data_out  = data_r;
   assign dm_write  = dmw_r;
   assign fma_start = start_r;
   assign error     = err_r;
   assign stage     = state_r;

endmodule

// File: tb/tb_fma_operand_sequencer.sv
// Directed bench for fma_operand_sequencer: a cycle model checked every cycle plus
// hand-computed expectations for debounce latency, loading, result, timeout and reset.
module tb_fma_operand_sequencer;
   localparam int DB = 4;
   localparam int TO = 8;

   logic        clk_100MHz = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] sw = 16'h0000;
   logic        btn_load = 1'b0;
   logic        fma_done = 1'b0;
   logic [15:0] fma_result = 16'h0000;
   logic [15:0] op_a, op_b, op_c, data_out;
   logic        fma_start, dm_write, error;
   logic [2:0]  stage;

   int checks = 0;
   int failures = 0;
   int dmw_seen = 0;
   int start_seen = 0;
   logic chk_en = 1'b0;
   logic prev_dmw = 1'b0;
   logic prev_start = 1'b0;

   // model state: raw-button history, accepted level, phase and outputs
   logic        m_s1, m_s2, m_level, m_level_prev;
   int          m_run, m_phase, m_wait;
   logic [15:0] m_op [3];
   logic [15:0] m_dout;
   logic        m_dmw, m_start, m_err;

   fma_operand_sequencer #(.DEBOUNCE_CYCLES(DB), .FMA_TIMEOUT(TO)) dut (
      .clk_100MHz(clk_100MHz), .reset(reset), .sw(sw), .btn_load(btn_load),
      .fma_done(fma_done), .fma_result(fma_result), .op_a(op_a), .op_b(op_b),
      .op_c(op_c), .fma_start(fma_start), .data_out(data_out), .dm_write(dm_write),
      .stage(stage), .error(error));

   initial forever #5 clk_100MHz = ~clk_100MHz;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock of the reference behaviour, using inputs as seen at the edge
   task automatic model_step();
      logic press_now;
      if (reset) begin
         m_s1 = 1'b0; m_s2 = 1'b0; m_level = 1'b0; m_level_prev = 1'b0; m_run = 0;
         m_phase = 0; m_wait = 0; m_op[0] = 16'h0; m_op[1] = 16'h0; m_op[2] = 16'h0;
         m_dout = 16'h0; m_dmw = 1'b0; m_start = 1'b0; m_err = 1'b0;
      end else begin
         press_now = m_level && !m_level_prev;
         m_level_prev = m_level;
         if (m_s2 != m_level) begin
            m_run = m_run + 1;
            if (m_run == DB) begin
               m_level = m_s2;
               m_run = 0;
            end
         end else begin
            m_run = 0;
         end
         m_s2 = m_s1;
         m_s1 = btn_load;
         m_dmw = 1'b0;
         m_start = 1'b0;
         case (m_phase)
            0, 1, 2: if (press_now) begin
               m_op[m_phase] = sw; m_dout = sw; m_dmw = 1'b1; m_phase = m_phase + 1;
            end
            3: begin m_start = 1'b1; m_wait = 0; m_phase = 4; end
            4: if (fma_done) begin
               m_dout = fma_result; m_dmw = 1'b1; m_phase = 5;
            end else begin
               m_wait = m_wait + 1;
               if (m_wait == TO) begin
                  m_err = 1'b1; m_dout = 16'hEEEE; m_dmw = 1'b1; m_phase = 5;
               end
            end
            5: if (press_now) begin m_err = 1'b0; m_phase = 0; end
            default: m_phase = 0;
         endcase
      end
   endtask

   // Every-cycle comparison against the model
   initial begin : cmp
      forever begin
         @(posedge clk_100MHz);
         model_step();
         #1;
         if (chk_en) begin
            check("cyc_stage", {13'd0, stage}, {13'd0, 3'(m_phase)});
            check("cyc_op_a", op_a, m_op[0]);
            check("cyc_op_b", op_b, m_op[1]);
            check("cyc_op_c", op_c, m_op[2]);
            check("cyc_data_out", data_out, m_dout);
            check("cyc_dm_write", {15'd0, dm_write}, {15'd0, m_dmw});
            check("cyc_fma_start", {15'd0, fma_start}, {15'd0, m_start});
            check("cyc_error", {15'd0, error}, {15'd0, m_err});
            check("cyc_dmw_single", {15'd0, dm_write & prev_dmw}, 16'd0);
            check("cyc_start_single", {15'd0, fma_start & prev_start}, 16'd0);
         end
         prev_dmw = dm_write;
         prev_start = fma_start;
         if (dm_write === 1'b1) dmw_seen++;
         if (fma_start === 1'b1) start_seen++;
      end
   end

   task automatic step();
      @(posedge clk_100MHz);
      #1;
   endtask

   task automatic press(input logic [15:0] v);
      sw = v;
      btn_load = 1'b1;
      repeat (10) step();
      btn_load = 1'b0;
      repeat (10) step();
   endtask

   // Loads A and B, then C; returns one cycle after the C strobe with the button released
   task automatic load_three(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
      press(a);
      press(b);
      sw = c;
      btn_load = 1'b1;
      repeat (8) step();
      btn_load = 1'b0;
   endtask

   initial begin : main
      int base;
      repeat (3) step();
      chk_en = 1'b1;
      reset = 1'b0;
      check("rst_stage", {13'd0, stage}, 16'd0);
      check("rst_data_out", data_out, 16'h0000);
      check("rst_op_a", op_a, 16'h0000);
      check("rst_strobes", {14'd0, dm_write, fma_start}, 16'd0);
      check("rst_error", {15'd0, error}, 16'd0);

      // single debounced press: strobe 2+4 cycles after the raw edge, seen after the 7th edge
      base = dmw_seen;
      sw = 16'h3F80;
      btn_load = 1'b1;
      repeat (6) step();
      check("db_not_yet", {15'd0, dm_write}, 16'd0);
      step();
      check("db_dm_write", {15'd0, dm_write}, 16'd1);
      check("db_data_out", data_out, 16'h3F80);
      check("db_op_a", op_a, 16'h3F80);
      check("db_stage", {13'd0, stage}, 16'd1);
      repeat (5) step();
      btn_load = 1'b0;
      repeat (10) step();
      check("db_one_pulse", 16'(dmw_seen - base), 16'd1);

      // bouncing button: never stable long enough
      base = dmw_seen;
      for (int i = 0; i < 10; i++) begin
         btn_load = ~btn_load;
         step();
         step();
      end
      repeat (8) step();
      check("bounce_no_pulse", 16'(dmw_seen - base), 16'd0);
      check("bounce_stage", {13'd0, stage}, 16'd1);

      // full operation: 2 * 3 + 1 = 7 -> 40E0
      reset = 1'b1;
      step();
      reset = 1'b0;
      base = start_seen;
      press(16'h4000);
      press(16'h4040);
      sw = 16'h3F80;
      btn_load = 1'b1;
      repeat (7) step();
      check("c_dm_write", {15'd0, dm_write}, 16'd1);
      check("c_data_out", data_out, 16'h3F80);
      check("c_stage", {13'd0, stage}, 16'd3);
      check("c_no_start", {15'd0, fma_start}, 16'd0);
      step();
      btn_load = 1'b0;
      check("start_pulse", {15'd0, fma_start}, 16'd1);
      check("start_wait", {13'd0, stage}, 16'd4);
      step();
      step();
      fma_done = 1'b1;
      fma_result = 16'h40E0;
      step();
      fma_done = 1'b0;
      check("res_data_out", data_out, 16'h40E0);
      check("res_dm_write", {15'd0, dm_write}, 16'd1);
      check("res_stage", {13'd0, stage}, 16'd5);
      check("res_ops", op_b ^ op_c ^ op_a, 16'h4000 ^ 16'h4040 ^ 16'h3F80);
      check("start_once", 16'(start_seen - base), 16'd1);
      repeat (4) step();
      // a result strobe outside WAIT is ignored
      base = dmw_seen;
      fma_done = 1'b1;
      fma_result = 16'h1234;
      step();
      step();
      fma_done = 1'b0;
      check("stray_done_data", data_out, 16'h40E0);
      check("stray_done_pulse", 16'(dmw_seen - base), 16'd0);
      press(16'h0000);
      check("show_exit_stage", {13'd0, stage}, 16'd0);
      check("show_exit_hold", data_out, 16'h40E0);

      // timeout: 8 WAIT cycles without a result
      load_three(16'h1111, 16'h2222, 16'h3333);
      repeat (7) step();
      check("to_not_yet", {15'd0, error}, 16'd0);
      check("to_wait_stage", {13'd0, stage}, 16'd4);
      step();
      check("to_error", {15'd0, error}, 16'd1);
      check("to_data_out", data_out, 16'hEEEE);
      check("to_dm_write", {15'd0, dm_write}, 16'd1);
      repeat (8) step();
      press(16'h0000);
      check("to_clear_error", {15'd0, error}, 16'd0);
      check("to_clear_stage", {13'd0, stage}, 16'd0);
      check("to_hold_data", data_out, 16'hEEEE);

      // result on the last allowed WAIT cycle beats the timeout
      load_three(16'h5555, 16'h6666, 16'h7777);
      repeat (7) step();
      fma_done = 1'b1;
      fma_result = 16'h4120;
      step();
      fma_done = 1'b0;
      check("edge_data_out", data_out, 16'h4120);
      check("edge_error", {15'd0, error}, 16'd0);
      check("edge_stage", {13'd0, stage}, 16'd5);
      repeat (8) step();
      press(16'h0000);

      // reset in WAIT, then a late result
      load_three(16'h0001, 16'h0002, 16'h0003);
      repeat (3) step();
      check("rw_in_wait", {13'd0, stage}, 16'd4);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("rw_stage", {13'd0, stage}, 16'd0);
      check("rw_ops", op_a | op_b | op_c, 16'h0000);
      check("rw_data_out", data_out, 16'h0000);
      check("rw_error", {15'd0, error}, 16'd0);
      base = dmw_seen;
      fma_done = 1'b1;
      fma_result = 16'hABCD;
      step();
      step();
      fma_done = 1'b0;
      step();
      check("rw_late_pulse", 16'(dmw_seen - base), 16'd0);
      check("rw_late_data", data_out, 16'h0000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
